// File: rtl/matrix_ram_ctrl_pkg.sv
// Shared types, sizes and helpers for the matrix RAM sequencer.
package matrix_ram_ctrl_pkg;

    localparam int MAX_DIM     = 8;
    localparam int MATRIX_SIZE = MAX_DIM * MAX_DIM;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = $clog2(MATRIX_SIZE);
    localparam int DIM_W       = $clog2(MAX_DIM + 1);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] M_address_t;
    typedef logic [DIM_W-1:0]  dim_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } ctrl_state_e;

    // Out-of-range dimensions fall back to the largest supported matrix.
    function automatic dim_t clamp_dim(input dim_t d);
        if (d == dim_t'(0) || d > dim_t'(MAX_DIM)) begin
            return dim_t'(MAX_DIM);
        end else begin
            return d;
        end
    endfunction

    function automatic M_address_t last_index(input dim_t d);
        logic [2*DIM_W-1:0] sq;
        sq = (2*DIM_W)'(d) * (2*DIM_W)'(d);
        return M_address_t'(sq - (2*DIM_W)'(1));
    endfunction

endpackage

// File: rtl/matrix_ram_ctrl_mat_idx_counter.sv
// Row-major index walker: linear pointer plus column position, wrapping at the
// final element of the matrix.
module matrix_ram_ctrl_mat_idx_counter
    import matrix_ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       step,
    input  dim_t       dim,
    input  M_address_t last_idx,
    output M_address_t ptr,
    output logic       col_last,
    output logic       mat_last
);

    M_address_t ptr_r;
    dim_t       col_r;

    always_comb begin
        ptr      = ptr_r;
        col_last = (col_r == dim - dim_t'(1));
        mat_last = (ptr_r == last_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= M_address_t'(0);
            col_r <= dim_t'(0);
        end else if (clear) begin
            ptr_r <= M_address_t'(0);
            col_r <= dim_t'(0);
        end else if (step) begin
            if (mat_last) begin
                ptr_r <= M_address_t'(0);
                col_r <= dim_t'(0);
            end else begin
                ptr_r <= ptr_r + M_address_t'(1);
                col_r <= col_last ? dim_t'(0) : col_r + dim_t'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_ram_ctrl.sv
// Matrix RAM sequencer: loads a row-major matrix into the RAM, then replays it
// to the MAC stage for the requested number of passes.
module matrix_ram_ctrl
    import matrix_ram_ctrl_pkg::*;
#(
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  dim_t              dim,
    input  logic [PASS_W-1:0] passes,
    input  logic              in_valid,
    input  data_t             in_data,
    output logic              in_ready,
    output logic              ram_wr_en,
    output M_address_t        ram_count_push,
    output data_t             ram_data_in,
    output logic              ram_rd_en,
    output M_address_t        ram_count_pop,
    input  data_t             ram_data_out,
    output logic              out_valid,
    output data_t             out_data,
    input  logic              out_ready,
    output logic              out_row_last,
    output logic              out_mat_last,
    output logic              busy,
    output logic              done
);

    localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};
    localparam logic [PASS_W-1:0] PASS_ONE  = {{(PASS_W-1){1'b0}}, 1'b1};

    ctrl_state_e       state_r, state_next;
    dim_t              dim_r, dim_eff;
    M_address_t        last_idx_r;
    logic [PASS_W-1:0] passes_r, pass_cnt_r;
    logic              out_valid_r, out_row_last_r, out_mat_last_r, out_final_r;
    logic              start_ok, wr_step, issue, handshake, done_s;
    M_address_t        wr_ptr, rd_ptr;
    logic              wr_col_last, wr_mat_last, rd_col_last, rd_mat_last;

    matrix_ram_ctrl_mat_idx_counter u_wr_idx (
        .clk(clk), .rst(rst), .clear(start_ok), .step(wr_step),
        .dim(dim_r), .last_idx(last_idx_r),
        .ptr(wr_ptr), .col_last(wr_col_last), .mat_last(wr_mat_last)
    );

    matrix_ram_ctrl_mat_idx_counter u_rd_idx (
        .clk(clk), .rst(rst), .clear(start_ok), .step(issue),
        .dim(dim_r), .last_idx(last_idx_r),
        .ptr(rd_ptr), .col_last(rd_col_last), .mat_last(rd_mat_last)
    );

    // Handshakes and RAM pin drive; pins stay at zero whenever they are unused.
    always_comb begin
        dim_eff   = clamp_dim(dim);
        start_ok  = (state_r == IDLE) && start;
        in_ready  = (state_r == LOAD);
        wr_step   = in_valid && in_ready;
        // Issuing refills the output register either when it is empty or as it drains.
        issue     = (state_r == READ) && (pass_cnt_r != passes_r) && (!out_valid_r || out_ready);
        handshake = out_valid_r && out_ready;
        done_s    = handshake && out_final_r;

        ram_wr_en      = wr_step;
        ram_count_push = wr_step ? wr_ptr : M_address_t'(0);
        ram_data_in    = wr_step ? in_data : data_t'(0);
        ram_rd_en      = issue;
        ram_count_pop  = issue ? rd_ptr : M_address_t'(0);

        out_valid    = out_valid_r;
        out_data     = out_valid_r ? ram_data_out : data_t'(0);
        out_row_last = out_row_last_r;
        out_mat_last = out_mat_last_r;
        busy         = (state_r != IDLE);
        done         = done_s;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next = LOAD;
                else       state_next = IDLE;
            end
            LOAD: begin
                if (wr_step && wr_mat_last && wr_col_last) state_next = READ;
                else                                       state_next = LOAD;
            end
            READ: begin
                if (done_s) state_next = IDLE;
                else        state_next = READ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_guard(state_next);
    end

    function automatic ctrl_state_e next_state_guard(input ctrl_state_e s);
        return s;
    endfunction

    // Job parameters, pass counter and the output staging register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dim_r          <= dim_t'(0);
            last_idx_r     <= M_address_t'(0);
            passes_r       <= PASS_ZERO;
            pass_cnt_r     <= PASS_ZERO;
            out_valid_r    <= 1'b0;
            out_row_last_r <= 1'b0;
            out_mat_last_r <= 1'b0;
            out_final_r    <= 1'b0;
        end else begin
            if (start_ok) begin
                dim_r      <= dim_eff;
                last_idx_r <= last_index(dim_eff);
                passes_r   <= (passes == PASS_ZERO) ? PASS_ONE : passes;
                pass_cnt_r <= PASS_ZERO;
            end else if (issue && rd_mat_last) begin
                pass_cnt_r <= pass_cnt_r + PASS_ONE;
            end

            if (issue) begin
                out_valid_r    <= 1'b1;
                out_row_last_r <= rd_col_last;
                out_mat_last_r <= rd_mat_last;
                out_final_r    <= rd_mat_last && (pass_cnt_r == passes_r - PASS_ONE);
            end else if (handshake) begin
                out_valid_r    <= 1'b0;
                out_row_last_r <= 1'b0;
                out_mat_last_r <= 1'b0;
                out_final_r    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_ram_ctrl.sv
// Scoreboard bench for matrix_ram_ctrl with a behavioural registered-read RAM.
module tb_matrix_ram_ctrl;
    import matrix_ram_ctrl_pkg::*;

    localparam int PASS_W = 4;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, out_ready;
    dim_t              dim;
    logic [PASS_W-1:0] passes;
    data_t             in_data, ram_data_in, ram_data_out, out_data;
    logic              in_ready, ram_wr_en, ram_rd_en, out_valid;
    logic              out_row_last, out_mat_last, busy, done;
    M_address_t        ram_count_push, ram_count_pop;

    matrix_ram_ctrl #(.PASS_W(PASS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .dim(dim), .passes(passes),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_wr_en(ram_wr_en), .ram_count_push(ram_count_push), .ram_data_in(ram_data_in),
        .ram_rd_en(ram_rd_en), .ram_count_pop(ram_count_pop), .ram_data_out(ram_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_row_last(out_row_last), .out_mat_last(out_mat_last),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    data_t mem [MATRIX_SIZE];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_count_push] <= ram_data_in;
        if (ram_rd_en) ram_data_out <= mem[ram_count_pop];
    end

    typedef struct packed {data_t data; logic row_last; logic mat_last; logic done;} out_t;
    typedef struct packed {M_address_t addr; data_t data;} wr_t;

    out_t exp_q[$];
    wr_t  wr_q[$];
    int   n_vec = 0, n_fail = 0, out_cnt = 0, done_cnt = 0, gap_cnt = 0;
    logic seen_out = 1'b0, rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        out_t  e;
        wr_t   w;
        data_t prev_data;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev_data  = data_t'(0);
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_elem", {out_data, out_row_last, out_mat_last, done}, e);
                end
                out_cnt++;
                seen_out = 1'b1;
            end else if (done) begin
                check("done_without_handshake", 64'd1, 64'd0);
            end
            if (seen_out && busy && !out_valid) gap_cnt++;
            if (done) done_cnt++;
            if (ram_wr_en) begin
                if (ram_rd_en) check("wr_rd_overlap", 64'd1, 64'd0);
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("ram_write", {ram_count_push, ram_data_in}, w);
                end
            end
            prev_stall = !rst && out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin : ready_driver
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_matrix(input int d, input int p, input data_t base);
        int n;
        n = d * d;
        for (int i = 0; i < n; i++) wr_q.push_back('{addr: M_address_t'(i), data: base + data_t'(i)});
        for (int pp = 0; pp < p; pp++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{data: base + data_t'(i), row_last: ((i % d) == d - 1),
                                  mat_last: (i == n - 1), done: (pp == p - 1) && (i == n - 1)});
            end
        end
    endtask

    task automatic do_start(input dim_t d, input logic [PASS_W-1:0] p);
        dim      = d;
        passes   = p;
        start    = 1'b1;
        seen_out = 1'b0;
        gap_cnt  = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input int n, input data_t base, input int bubble_mod,
                        input int restart_at, input dim_t restart_dim);
        int i, guard;
        bit acc;
        i = 0;
        guard = 0;
        while (i < n && guard < 4 * n + 100) begin
            in_valid = (bubble_mod == 0) ? 1'b1 : ((guard % bubble_mod) != 0);
            in_data  = base + data_t'(i);
            if (i == restart_at && in_valid) begin
                start = 1'b1;
                dim   = restart_dim;
            end else begin
                start = 1'b0;
            end
            acc = in_valid && in_ready;
            tick();
            guard++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < n) check("load_timeout", 64'(i), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        check("idle_within_budget", 64'(busy), 64'd0);
    endtask

    task automatic finish_case(input int done_base, input int exp_done, input bit gap_check);
        check("outputs_drained", 64'(exp_q.size()), 64'd0);
        check("writes_drained", 64'(wr_q.size()), 64'd0);
        check("done_pulses", 64'(done_cnt - done_base), 64'(exp_done));
        if (gap_check) check("no_output_gap", 64'(gap_cnt), 64'd0);
    endtask

    initial begin : stimulus
        int db, oc;
        rst = 1'b1; start = 1'b0; dim = dim_t'(0); passes = '0;
        in_valid = 1'b0; in_data = data_t'(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {busy, in_ready, out_valid, ram_wr_en, ram_rd_en, done, out_row_last, out_mat_last},
              8'h00);
        check("reset_addr", {ram_count_push, ram_count_pop, out_data, ram_data_in}, '0);
        rst = 1'b0;
        tick();

        // dim=4, single pass, back-to-back everything
        db = done_cnt;
        expect_matrix(4, 1, 16'h0000);
        do_start(4'd4, 4'd1);
        load(16, 16'h0000, 0, -1, 4'd0);
        wait_idle(200);
        finish_case(db, 1, 1'b1);

        // dim=3, three passes with load bubbles; passes must abut
        db = done_cnt;
        expect_matrix(3, 3, 16'h0200);
        do_start(4'd3, 4'd3);
        load(9, 16'h0200, 3, -1, 4'd0);
        wait_idle(200);
        finish_case(db, 1, 1'b1);

        // dim=4 with random backpressure
        db = done_cnt;
        rand_ready = 1'b1;
        expect_matrix(4, 1, 16'h0300);
        do_start(4'd4, 4'd1);
        load(16, 16'h0300, 0, -1, 4'd0);
        wait_idle(1000);
        rand_ready = 1'b0;
        tick();
        finish_case(db, 1, 1'b0);

        // dim=1, passes=0 behaves as one pass
        db = done_cnt;
        expect_matrix(1, 1, 16'h0400);
        do_start(4'd1, 4'd0);
        load(1, 16'h0400, 0, -1, 4'd0);
        wait_idle(50);
        finish_case(db, 1, 1'b1);

        // reset after 5 outputs of a dim=4 read
        db = done_cnt;
        expect_matrix(4, 1, 16'h0500);
        do_start(4'd4, 4'd1);
        load(16, 16'h0500, 0, -1, 4'd0);
        oc = out_cnt;
        for (int k = 0; k < 100 && out_cnt < oc + 5; k++) tick();
        check("five_outputs_before_reset", 64'(out_cnt - oc), 64'd5);
        rst = 1'b1;
        #1;
        check("reset_mid_read", {busy, out_valid, ram_rd_en, ram_wr_en, done, in_ready, out_row_last, out_mat_last},
              8'h00);
        check("reset_mid_read_data", {out_data, ram_count_pop}, '0);
        exp_q.delete();
        wr_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("no_done_on_reset", 64'(done_cnt - db), 64'd0);
        expect_matrix(2, 1, 16'h0580);
        do_start(4'd2, 4'd1);
        load(4, 16'h0580, 0, -1, 4'd0);
        wait_idle(100);
        finish_case(db, 1, 1'b1);

        // dim=9 clamps to 8; a start during LOAD with dim=2 is ignored
        db = done_cnt;
        expect_matrix(8, 1, 16'h0600);
        do_start(4'd9, 4'd1);
        load(64, 16'h0600, 0, 10, 4'd2);
        wait_idle(300);
        finish_case(db, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
